// File: rtl/cpu_test_ctrl.sv
// Test controller: sequences CPU reset release, detects end-of-test via a tohost store, runs a cycle watchdog.
// Optional signature capture window is built only when CPU_TEST_CTRL_SIG_EN is defined.
module cpu_test_ctrl #(
    parameter int          RESET_HOLD_CYCLES = 4,
    parameter logic [31:0] TIMEOUT_CYCLES    = 32'd10000,
    parameter logic [31:0] TOHOST_ADDR       = 32'h0000_03F0,
    parameter logic [31:0] SIG_BASE          = 32'h0000_0200,
    parameter int          NUM_SIG           = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   mem_wr_en,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_data_in,
    output logic                   cpu_resetn,
    output logic                   running,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [30:0]            fail_code,
    output logic [31:0]            cycle_count,
    output logic [32*NUM_SIG-1:0]  sig_data,
    output logic [NUM_SIG-1:0]     sig_valid
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  HOLD_LAST    = 8'(RESET_HOLD_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;
    localparam logic [32:0] SIG_END      = {1'b0, SIG_BASE} + 33'(4 * NUM_SIG);

    if (RESET_HOLD_CYCLES < 1 || RESET_HOLD_CYCLES > 255) begin : g_bad_hold
        $error("cpu_test_ctrl: RESET_HOLD_CYCLES out of range 1..255");
    end
    if (TIMEOUT_CYCLES == 32'd0) begin : g_bad_timeout
        $error("cpu_test_ctrl: TIMEOUT_CYCLES must be nonzero");
    end
    if (NUM_SIG < 1 || NUM_SIG > 16) begin : g_bad_num_sig
        $error("cpu_test_ctrl: NUM_SIG out of range 1..16");
    end
    if (SIG_BASE[1:0] != 2'b00) begin : g_bad_sig_align
        $error("cpu_test_ctrl: SIG_BASE must be word aligned");
    end
    if (SIG_END > 33'h1_0000_0000) begin : g_bad_sig_window
        $error("cpu_test_ctrl: signature window wraps past 2^32");
    end

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  hold_cnt_r;
    logic        hold_end_s;
    logic        tohost_hit_s;
    logic        wd_hit_s;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_HOLD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a tohost store outranks the watchdog in the same cycle
    always_comb begin
        state_s      = state_r;
        hold_end_s   = 1'b0;
        tohost_hit_s = 1'b0;
        wd_hit_s     = 1'b0;
        case (state_r)
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    hold_end_s = 1'b1;
                    state_s    = ST_RUN;
                end else begin
                    state_s    = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (mem_wr_en && (mem_addr == TOHOST_ADDR)) begin
                    tohost_hit_s = 1'b1;
                    state_s      = ST_DONE;
                end else if (cycle_count == TIMEOUT_LAST) begin
                    wd_hit_s     = 1'b1;
                    state_s      = ST_DONE;
                end else begin
                    state_s      = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_HOLD;
        endcase
    end

    // Hold counter and run-cycle counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_cnt_r  <= 8'd0;
            cycle_count <= 32'd0;
        end else begin
            if (state_r == ST_HOLD) begin
                hold_cnt_r <= hold_cnt_r + 8'd1;
            end
            if (state_r == ST_RUN) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

    // Status outputs; fail_code is data>>1, which is already 0 for a passing store of 1
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_resetn <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_code  <= 31'd0;
        end else if (hold_end_s) begin
            cpu_resetn <= 1'b1;
            running    <= 1'b1;
        end else if (tohost_hit_s) begin
            cpu_resetn <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b1;
            pass       <= (mem_data_in == 32'd1);
            fail_code  <= mem_data_in[31:1];
        end else if (wd_hit_s) begin
            cpu_resetn <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            timeout    <= 1'b1;
        end
    end

`ifdef CPU_TEST_CTRL_SIG_EN
    localparam logic [29:0] SIG_WBASE = SIG_BASE[31:2];

    // Signature capture: word-granular match, byte offset ignored, RUN only
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sig_data  <= '0;
            sig_valid <= '0;
        end else if ((state_r == ST_RUN) && mem_wr_en) begin
            for (int k = 0; k < NUM_SIG; k++) begin
                if (mem_addr[31:2] == (SIG_WBASE + 30'(k))) begin
                    sig_data[32*k +: 32] <= mem_data_in;
                    sig_valid[k]         <= 1'b1;
                end
            end
        end
    end
`else
    assign sig_data  = '0;
    assign sig_valid = '0;
`endif

endmodule

// File: tb/tb_cpu_test_ctrl.sv
// Randomised self-checking bench for cpu_test_ctrl against a session-level outcome model.
module tb_cpu_test_ctrl;

    localparam int          HOLD   = 4;
    localparam int          TO     = 50;
    localparam logic [31:0] TOHOST = 32'h0000_03F0;
    localparam logic [31:0] SIGB   = 32'h0000_0200;
    localparam int          NSIG   = 4;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  mem_wr_en = 1'b0;
    logic [31:0]           mem_addr = 32'd0;
    logic [31:0]           mem_data_in = 32'd0;
    logic                  cpu_resetn, running, done, pass, timeout;
    logic [30:0]           fail_code;
    logic [31:0]           cycle_count;
    logic [32*NSIG-1:0]    sig_data;
    logic [NSIG-1:0]       sig_valid;

    int checks = 0;
    int errors = 0;

    // model expectations for the last session
    logic                  exp_pass, exp_timeout;
    logic [30:0]           exp_fail;
    logic [31:0]           exp_count;
    logic [31:0]           exp_sig [NSIG];
    logic [NSIG-1:0]       exp_valid;
    logic [32*NSIG-1:0]    exp_flat;

    // directed stores injected into the next session
    int          dq_cycle [$];
    logic [31:0] dq_addr  [$];
    logic [31:0] dq_data  [$];

    cpu_test_ctrl #(
        .RESET_HOLD_CYCLES (HOLD),
        .TIMEOUT_CYCLES    (32'(TO)),
        .TOHOST_ADDR       (TOHOST),
        .SIG_BASE          (SIGB),
        .NUM_SIG           (NSIG)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .cpu_resetn  (cpu_resetn),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_code   (fail_code),
        .cycle_count (cycle_count),
        .sig_data    (sig_data),
        .sig_valid   (sig_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish in time");
        $fatal(1, "bench watchdog expired");
    end

    task automatic release_reset();
        resetn    = 1'b0;
        mem_wr_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (HOLD) @(negedge clk);
    endtask

    function automatic void build_flat();
        for (int k = 0; k < NSIG; k++) exp_flat[32*k +: 32] = exp_sig[k];
    endfunction

    // Drives one session from RUN cycle 0; the model records the outcome the session must produce.
    task automatic run_session(input int th_cycle, input logic [31:0] th_data, input int pct, input int n_after);
        int          last;
        bit          has_th;
        bit          we;
        logic [31:0] a, d;
        has_th = (th_cycle >= 0) && (th_cycle < TO);
        last   = has_th ? th_cycle : TO - 1;
        for (int k = 0; k < NSIG; k++) exp_sig[k] = 32'd0;
        exp_valid = '0;
        for (int t = 0; t <= last + n_after; t++) begin
            we = 1'b0;
            a  = $urandom;
            d  = $urandom;
            if (has_th && t == th_cycle) begin
                we = 1'b1; a = TOHOST; d = th_data;
            end else begin
                for (int i = 0; i < dq_cycle.size(); i++) begin
                    if (dq_cycle[i] == t) begin
                        we = 1'b1; a = dq_addr[i]; d = dq_data[i];
                    end
                end
                if (!we && $urandom_range(99) < pct) begin
                    we = 1'b1;
                    a  = SIGB - 32'd8 + 32'(4 * $urandom_range(NSIG + 3)) + 32'($urandom_range(3));
                    if (t > last && $urandom_range(1) == 1) a = TOHOST;
                end else if (!we && $urandom_range(3) == 0) begin
                    a = TOHOST;
                end
            end
            mem_wr_en = we; mem_addr = a; mem_data_in = d;
`ifdef CPU_TEST_CTRL_SIG_EN
            if (we && t <= last && a >= SIGB && a < SIGB + 32'(4 * NSIG)) begin
                exp_sig[int'((a - SIGB) >> 2)]   = d;
                exp_valid[int'((a - SIGB) >> 2)] = 1'b1;
            end
`endif
            @(negedge clk);
        end
        mem_wr_en   = 1'b0;
        exp_pass    = has_th && (th_data == 32'd1);
        exp_timeout = !has_th;
        exp_fail    = has_th ? th_data[31:1] : 31'd0;
        exp_count   = 32'(last + 1);
        build_flat();
        dq_cycle.delete(); dq_addr.delete(); dq_data.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_resetn, running, done, pass, timeout} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {cpu_resetn, running, done, pass, timeout});
        end
        checks++;
        if (fail_code !== 31'd0 || cycle_count !== 32'd0) begin
            errors++; $display("FAIL reset_counts got fail=%0d count=%0d want 0 0", fail_code, cycle_count);
        end
        checks++;
        if (sig_data !== '0 || sig_valid !== '0) begin
            errors++; $display("FAIL reset_sig got valid=%b want 0", sig_valid);
        end
        resetn = 1'b1;
        for (int e = 1; e <= HOLD; e++) begin
            @(negedge clk);
            checks++;
            if (cpu_resetn !== (e == HOLD) || running !== (e == HOLD)) begin
                errors++; $display("FAIL hold_edge%0d got cpu_resetn=%b running=%b want %b", e, cpu_resetn, running, e == HOLD);
            end
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            errors++; $display("FAIL run_start_count got %0d want 0", cycle_count);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (cycle_count !== 32'd7 || done !== 1'b0) begin
            errors++; $display("FAIL run_count7 got %0d done=%b want 7 0", cycle_count, done);
        end
    endtask

    task automatic test_pass();
        release_reset();
        run_session(20, 32'd1, 30, 0);
        checks++;
        if ({done, pass, timeout, cpu_resetn, running} !== 5'b11000 || fail_code !== 31'd0) begin
            errors++; $display("FAIL pass_flags got d%b p%b t%b c%b r%b fc=%0d want 11000 fc=0", done, pass, timeout, cpu_resetn, running, fail_code);
        end
        checks++;
        if (cycle_count !== exp_count || exp_count !== 32'd21) begin
            errors++; $display("FAIL pass_count got %0d want 21", cycle_count);
        end
        mem_wr_en = 1'b1; mem_addr = TOHOST; mem_data_in = 32'd7;
        @(negedge clk);
        mem_addr = SIGB; mem_data_in = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (pass !== 1'b1 || fail_code !== 31'd0 || cycle_count !== 32'd21 || sig_data !== exp_flat || sig_valid !== exp_valid) begin
            errors++; $display("FAIL done_sticky got p%b fc=%0d count=%0d valid=%b want 1 0 21 %b", pass, fail_code, cycle_count, sig_valid, exp_valid);
        end
    endtask

    task automatic test_fail_code();
        release_reset();
        run_session(13, 32'h0000_0007, 30, 2);
        checks++;
        if ({done, pass, timeout} !== 3'b100 || fail_code !== 31'd3 || cycle_count !== 32'd14) begin
            errors++; $display("FAIL fail7 got d%b p%b t%b fc=%0d count=%0d want 100 fc=3 count=14", done, pass, timeout, fail_code, cycle_count);
        end
        release_reset();
        run_session(5, 32'd0, 0, 1);
        checks++;
        if ({done, pass, timeout} !== 3'b100 || fail_code !== 31'd0) begin
            errors++; $display("FAIL fail0 got d%b p%b t%b fc=%0d want 100 fc=0", done, pass, timeout, fail_code);
        end
    endtask

    task automatic test_timeout();
        release_reset();
        run_session(-1, 32'd0, 30, 3);
        checks++;
        if ({done, pass, timeout, cpu_resetn} !== 4'b1010 || cycle_count !== 32'd50 || cycle_count !== exp_count) begin
            errors++; $display("FAIL timeout got d%b p%b t%b c%b count=%0d want 1010 count=50", done, pass, timeout, cpu_resetn, cycle_count);
        end
        release_reset();
        run_session(49, 32'd1, 30, 3);
        checks++;
        if ({done, pass, timeout} !== 3'b110 || cycle_count !== 32'd50) begin
            errors++; $display("FAIL tiebreak got d%b p%b t%b count=%0d want 110 count=50", done, pass, timeout, cycle_count);
        end
    endtask

    task automatic test_signature();
        logic [NSIG-1:0] want_valid;
        logic [31:0]     want_w0, want_w3;
`ifdef CPU_TEST_CTRL_SIG_EN
        want_valid = 4'b1001; want_w0 = 32'h70; want_w3 = 32'hAA;
`else
        want_valid = 4'b0000; want_w0 = 32'h0;  want_w3 = 32'h0;
`endif
        dq_cycle = '{2, 4, 6, 8};
        dq_addr  = '{32'h200, 32'h20C, 32'h210, 32'h200};
        dq_data  = '{32'h69, 32'hAA, 32'h55, 32'h70};
        release_reset();
        run_session(12, 32'd1, 0, 1);
        checks++;
        if (sig_valid !== want_valid || sig_data[31:0] !== want_w0 || sig_data[127:96] !== want_w3) begin
            errors++; $display("FAIL sig_directed got valid=%b w0=%h w3=%h want %b %h %h", sig_valid, sig_data[31:0], sig_data[127:96], want_valid, want_w0, want_w3);
        end
        checks++;
        if (sig_data !== exp_flat || sig_valid !== exp_valid) begin
            errors++; $display("FAIL sig_model got %h want %h", sig_data, exp_flat);
        end
    endtask

    task automatic test_mid_run_reset();
        logic [31:0] d;
        d = $urandom;
        release_reset();
        mem_wr_en = 1'b1; mem_addr = SIGB + 32'd5; mem_data_in = d;
        @(negedge clk);
        mem_wr_en = 1'b0;
        checks++;
`ifdef CPU_TEST_CTRL_SIG_EN
        if (sig_valid !== 4'b0010 || sig_data[63:32] !== d) begin
            errors++; $display("FAIL sig_latency got valid=%b w1=%h want 0010 %h", sig_valid, sig_data[63:32], d);
        end
`else
        if (sig_valid !== 4'b0000 || sig_data !== '0) begin
            errors++; $display("FAIL sig_tied got valid=%b want 0000", sig_valid);
        end
`endif
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({cpu_resetn, running, done, pass, timeout} !== 5'b0 || cycle_count !== 32'd0 || sig_valid !== '0 || sig_data !== '0) begin
            errors++; $display("FAIL async_reset got flags=%b count=%0d valid=%b want 0", {cpu_resetn, running, done, pass, timeout}, cycle_count, sig_valid);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int e = 1; e <= HOLD; e++) begin
            @(negedge clk);
            checks++;
            if (cpu_resetn !== (e == HOLD)) begin
                errors++; $display("FAIL rehold_edge%0d got %b want %b", e, cpu_resetn, e == HOLD);
            end
        end
    endtask

    task automatic test_random();
        int          th;
        logic [31:0] dat;
        for (int r = 0; r < 8; r++) begin
            th = $urandom_range(60);
            case ($urandom_range(3))
                0:       dat = 32'd1;
                1:       dat = 32'd0;
                default: dat = $urandom;
            endcase
            release_reset();
            run_session(th, dat, 45, $urandom_range(4));
            checks++;
            if (done !== 1'b1 || pass !== exp_pass || timeout !== exp_timeout || fail_code !== exp_fail) begin
                errors++; $display("FAIL rand%0d_status th=%0d got p%b t%b fc=%0d want p%b t%b fc=%0d", r, th, pass, timeout, fail_code, exp_pass, exp_timeout, exp_fail);
            end
            checks++;
            if (cycle_count !== exp_count || cpu_resetn !== 1'b0 || running !== 1'b0) begin
                errors++; $display("FAIL rand%0d_count got %0d c%b r%b want %0d 0 0", r, cycle_count, cpu_resetn, running, exp_count);
            end
            checks++;
            if (sig_data !== exp_flat || sig_valid !== exp_valid) begin
                errors++; $display("FAIL rand%0d_sig got valid=%b want %b", r, sig_valid, exp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_code();
        test_timeout();
        test_signature();
        test_mid_run_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
